// File: rtl/tdm_demux3.sv
// ---------------------------------------------------------------------------
// tdm_demux3
// Three-channel time-division demultiplexer. A single serial word stream, in
// which a SYNC flag marks the channel-0 word, is split onto three registered
// per-channel outputs. A two-state lock FSM (HUNT/LOCK) plus a slot counter
// track frame alignment, and sync violations are reported with a pulse.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   D           incoming multiplexed data word (WIDTH bits)
//   D_valid     D carries a valid word this cycle
//   SYNC        marks D as the channel-0 word (sampled only when D_valid=1)
//   Y0/Y1/Y2    registered per-channel data, held until that channel's next write
//   V0/V1/V2    one-cycle strobe, matching Yn updated this cycle
//   FRAME_DONE  one-cycle pulse when the channel-2 word of an aligned frame lands
//   SYNC_ERR    one-cycle pulse on a missing or early sync
//   LOCKED      high while the FSM is in LOCK
// ---------------------------------------------------------------------------
module tdm_demux3 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    input  logic             SYNC,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic             V0,
    output logic             V1,
    output logic             V2,
    output logic             FRAME_DONE,
    output logic             SYNC_ERR,
    output logic             LOCKED
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_slot;
    logic [1:0] w_nextSlot;

    logic       w_wrY0;
    logic       w_wrY1;
    logic       w_wrY2;
    logic       w_frameDone;
    logic       w_syncErr;

    // State register: holds the lock state and the slot position within the
    // current frame. Reset drops back to hunting at slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_slot  <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_slot  <= w_nextSlot;
        end
    end

    // Next-state logic: idle cycles leave alignment untouched. In HUNT only a
    // SYNC word can start a frame. In LOCK a SYNC always restarts the frame at
    // slot 1 (early sync resyncs without leaving LOCK), while a non-SYNC word
    // arriving at slot 0 means the expected sync is missing, so alignment is
    // abandoned. Slot 3 is unreachable and is treated like a missing sync.
    always_comb begin
        w_nextState = r_state;
        w_nextSlot  = r_slot;
        if (D_valid) begin
            if (r_state == HUNT) begin
                if (SYNC) begin
                    w_nextState = LOCK;
                    w_nextSlot  = 2'd1;
                end
            end else if (SYNC) begin
                w_nextSlot = 2'd1;
            end else begin
                case (r_slot)
                    2'd1:    w_nextSlot = 2'd2;
                    2'd2:    w_nextSlot = 2'd0;
                    default: begin
                        w_nextState = HUNT;
                        w_nextSlot  = 2'd0;
                    end
                endcase
            end
        end
    end

    // Output decode: decides which channel (if any) the current word is
    // written to and which status pulses fire. These are registered below so
    // every output appears one cycle after its word is sampled.
    always_comb begin
        w_wrY0      = 1'b0;
        w_wrY1      = 1'b0;
        w_wrY2      = 1'b0;
        w_frameDone = 1'b0;
        w_syncErr   = 1'b0;
        if (D_valid) begin
            if (r_state == HUNT) begin
                w_wrY0 = SYNC;
            end else if (SYNC) begin
                w_wrY0    = 1'b1;
                w_syncErr = (r_slot != 2'd0);
            end else begin
                case (r_slot)
                    2'd1:    w_wrY1 = 1'b1;
                    2'd2: begin
                        w_wrY2      = 1'b1;
                        w_frameDone = 1'b1;
                    end
                    default: w_syncErr = 1'b1;
                endcase
            end
        end
    end

    // Output registers: data words are captured only on their channel's
    // write so each Yn holds its last value; strobes and pulses are simply
    // the registered decode and therefore last exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y0         <= '0;
            Y1         <= '0;
            Y2         <= '0;
            V0         <= 1'b0;
            V1         <= 1'b0;
            V2         <= 1'b0;
            FRAME_DONE <= 1'b0;
            SYNC_ERR   <= 1'b0;
        end else begin
            if (w_wrY0) Y0 <= D;
            if (w_wrY1) Y1 <= D;
            if (w_wrY2) Y2 <= D;
            V0         <= w_wrY0;
            V1         <= w_wrY1;
            V2         <= w_wrY2;
            FRAME_DONE <= w_frameDone;
            SYNC_ERR   <= w_syncErr;
        end
    end

    // LOCKED comes straight from the state register, so it rises together
    // with the first V0 and falls together with a missing-sync SYNC_ERR.
    assign LOCKED = (r_state == LOCK);

endmodule

// File: tb/tb_tdm_demux3.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux3
// Directed bench for tdm_demux3. Each driven word is fed through a small
// behavioural model of the demultiplexer; the expected outputs are pushed to
// a scoreboard queue and popped for comparison one cycle later.
// ---------------------------------------------------------------------------
module tb_tdm_demux3;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] D;
    logic             D_valid;
    logic             SYNC;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;
    logic [WIDTH-1:0] Y2;
    logic             V0;
    logic             V1;
    logic             V2;
    logic             FRAME_DONE;
    logic             SYNC_ERR;
    logic             LOCKED;

    typedef struct packed {
        logic [WIDTH-1:0] y0;
        logic [WIDTH-1:0] y1;
        logic [WIDTH-1:0] y2;
        logic [5:0]       flags;
    } exp_t;

    exp_t             scoreboard[$];

    int               checks;
    int               errors;

    logic             mLock;
    logic [1:0]       mSlot;
    logic [WIDTH-1:0] mY0;
    logic [WIDTH-1:0] mY1;
    logic [WIDTH-1:0] mY2;

    tdm_demux3 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D          (D),
        .D_valid    (D_valid),
        .SYNC       (SYNC),
        .Y0         (Y0),
        .Y1         (Y1),
        .Y2         (Y2),
        .V0         (V0),
        .V1         (V1),
        .V2         (V2),
        .FRAME_DONE (FRAME_DONE),
        .SYNC_ERR   (SYNC_ERR),
        .LOCKED     (LOCKED)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any difference.
    task automatic cmp(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns the model to its power-on state.
    task automatic modelReset();
        mLock = 1'b0;
        mSlot = 2'd0;
        mY0   = '0;
        mY1   = '0;
        mY2   = '0;
    endtask

    // Drives one cycle of input at the falling edge, steps the behavioural
    // model and pushes the outputs expected after the next rising edge.
    // Flags are packed as {V0,V1,V2,FRAME_DONE,SYNC_ERR,LOCKED}.
    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic v, input logic s);
        exp_t e;
        logic v0, v1, v2, fd, er;
        @(negedge clk);
        D       = d;
        D_valid = v;
        SYNC    = s;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; fd = 1'b0; er = 1'b0;
        if (v) begin
            if (!mLock) begin
                if (s) begin
                    mY0 = d; v0 = 1'b1; mSlot = 2'd1; mLock = 1'b1;
                end
            end else if (s) begin
                er  = (mSlot != 2'd0);
                mY0 = d; v0 = 1'b1; mSlot = 2'd1;
            end else if (mSlot == 2'd1) begin
                mY1 = d; v1 = 1'b1; mSlot = 2'd2;
            end else if (mSlot == 2'd2) begin
                mY2 = d; v2 = 1'b1; fd = 1'b1; mSlot = 2'd0;
            end else begin
                er = 1'b1; mLock = 1'b0; mSlot = 2'd0;
            end
        end
        e.y0    = mY0;
        e.y1    = mY1;
        e.y2    = mY2;
        e.flags = {v0, v1, v2, fd, er, mLock};
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Pops the oldest expectation and compares it against the DUT outputs.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = scoreboard.pop_front();
            cmp({tag, ".Y0"}, Y0, e.y0);
            cmp({tag, ".Y1"}, Y1, e.y1);
            cmp({tag, ".Y2"}, Y2, e.y2);
            cmp({tag, ".flags"}, {2'b00, V0, V1, V2, FRAME_DONE, SYNC_ERR, LOCKED},
                {2'b00, e.flags});
        end
    endtask

    // One driven word followed by its comparison.
    task automatic step(input string tag, input logic [WIDTH-1:0] d, input logic v, input logic s);
        applyStimulus(d, v, s);
        checkOutput(tag);
    endtask

    // Checks that every output is at its reset value right now.
    task automatic checkAllZero(input string tag);
        cmp({tag, ".Y0"}, Y0, 8'h00);
        cmp({tag, ".Y1"}, Y1, 8'h00);
        cmp({tag, ".Y2"}, Y2, 8'h00);
        cmp({tag, ".flags"}, {2'b00, V0, V1, V2, FRAME_DONE, SYNC_ERR, LOCKED}, 8'h00);
    endtask

    // Directed sequence following the block's test plan.
    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        D       = '0;
        D_valid = 1'b0;
        SYNC    = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] aligned stream");
        step("al_A1", 8'hA1, 1'b1, 1'b1);
        step("al_B2", 8'hB2, 1'b1, 1'b0);
        step("al_C3", 8'hC3, 1'b1, 1'b0);
        step("al_D4", 8'hD4, 1'b1, 1'b1);
        step("al_E5", 8'hE5, 1'b1, 1'b0);
        step("al_F6", 8'hF6, 1'b1, 1'b0);

        $display("[TB] missing sync");
        step("ms_44", 8'h44, 1'b1, 1'b0);
        step("ms_55", 8'h55, 1'b1, 1'b1);
        step("ms_5A", 8'h5A, 1'b1, 1'b0);
        step("ms_5B", 8'h5B, 1'b1, 1'b0);
        step("ms_5C", 8'h5C, 1'b1, 1'b0);

        $display("[TB] hunt");
        step("hu_11", 8'h11, 1'b1, 1'b0);
        step("hu_22", 8'h22, 1'b1, 1'b0);
        step("hu_33", 8'h33, 1'b1, 1'b1);
        step("hu_3A", 8'h3A, 1'b1, 1'b0);
        step("hu_3B", 8'h3B, 1'b1, 1'b0);

        $display("[TB] early sync");
        step("es_01", 8'h01, 1'b1, 1'b1);
        step("es_02", 8'h02, 1'b1, 1'b0);
        step("es_03", 8'h03, 1'b1, 1'b1);
        step("es_04", 8'h04, 1'b1, 1'b0);
        step("es_05", 8'h05, 1'b1, 1'b0);

        $display("[TB] gaps");
        step("gp_10", 8'h10, 1'b1, 1'b1);
        step("gp_i1", 8'hEE, 1'b0, 1'b1);
        step("gp_i2", 8'hDD, 1'b0, 1'b0);
        step("gp_i3", 8'hCC, 1'b0, 1'b1);
        step("gp_20", 8'h20, 1'b1, 1'b0);
        step("gp_i4", 8'hBB, 1'b0, 1'b1);
        step("gp_30", 8'h30, 1'b1, 1'b0);
        step("gp_i5", 8'hAA, 1'b0, 1'b0);

        $display("[TB] async reset");
        step("ar_60", 8'h60, 1'b1, 1'b1);
        step("ar_61", 8'h61, 1'b1, 1'b0);
        rst_n   = 1'b0;
        D_valid = 1'b0;
        SYNC    = 1'b0;
        modelReset();
        #1;
        checkAllZero("ar_async");
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_77", 8'h77, 1'b1, 1'b0);
        step("ar_88", 8'h88, 1'b1, 1'b1);
        step("ar_89", 8'h89, 1'b1, 1'b0);
        step("ar_8A", 8'h8A, 1'b1, 1'b0);

        checks++;
        assert (scoreboard.size() == 0) else begin
            errors++;
            $error("[TB] FAIL sb_drain observed=%0d expected=0", scoreboard.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
